// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the CP0 exception producer: exception codes,
// CP0 register addresses, sequencer states and the event priority encoder.
package exception_ctrl_pkg;

  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_OVF     = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;
  localparam logic [31:0] EXC_ADDR    = 32'h0000_000f;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Software-writable CAUSE bits: IP[1:0] and IV/WP
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  function automatic logic [31:0] exc_code(input logic intr, input logic addr_err,
                                           input logic syscall, input logic inv,
                                           input logic trap, input logic ovf,
                                           input logic eret);
    logic [31:0] code;
    if (intr)          code = EXC_INT;
    else if (addr_err) code = EXC_ADDR;
    else if (syscall)  code = EXC_SYSCALL;
    else if (inv)      code = EXC_INV;
    else if (trap)     code = EXC_TRAP;
    else if (ovf)      code = EXC_OVF;
    else if (eret)     code = EXC_ERET;
    else               code = EXC_NONE;
    return code;
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// MEM-stage exception bundle between the pipeline/cp0_reg side (master) and
// the exception controller (slave).
interface exception_ctrl_if;
  logic        valid_i;
  logic [31:0] inst_addr_i;
  logic        in_delay_slot_i;
  logic [31:0] bad_addr_i;
  logic        addr_err_i;
  logic        syscall_i;
  logic        inst_invalid_i;
  logic        trap_i;
  logic        ovf_i;
  logic        eret_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;
  logic [31:0] excepttype_o;
  logic [31:0] cur_inst_addr_o;
  logic        in_delay_slot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output valid_i, inst_addr_i, in_delay_slot_i, bad_addr_i, addr_err_i,
           syscall_i, inst_invalid_i, trap_i, ovf_i, eret_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, cur_inst_addr_o, in_delay_slot_o, bad_addr_o,
           flush_o, new_pc_o
  );

  modport slave (
    input  valid_i, inst_addr_i, in_delay_slot_i, bad_addr_i, addr_err_i,
           syscall_i, inst_invalid_i, trap_i, ovf_i, eret_i,
           cp0_status_i, cp0_cause_i, cp0_epc_i,
           wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, cur_inst_addr_o, in_delay_slot_o, bad_addr_o,
           flush_o, new_pc_o
  );
endinterface

// File: rtl/exception_ctrl_cp0_fwd.sv
// Combinational bypass of STATUS/CAUSE/EPC from a CP0 write still sitting in WB,
// so the exception decision sees the value cp0_reg is about to hold.
module exception_ctrl_cp0_fwd
  import exception_ctrl_pkg::*;
(
  input  logic [31:0] status,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_data,
  output logic [31:0] status_f,
  output logic [31:0] cause_f,
  output logic [31:0] epc_f
);

  // Select WB data for the register being written, keep cp0_reg values otherwise
  always_comb begin
    status_f = status;
    cause_f  = cause;
    epc_f    = epc;
    if (wb_we) begin
      case (wb_waddr)
        CP0_REG_STATUS: status_f = wb_data;
        CP0_REG_CAUSE:  cause_f  = (cause & ~CAUSE_WR_MASK) | (wb_data & CAUSE_WR_MASK);
        CP0_REG_EPC:    epc_f    = wb_data;
        default:        status_f = status;
      endcase
    end else begin
      status_f = status;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM/commit-stage exception controller: prioritises exceptions and interrupts,
// reports the code to cp0_reg and holds the pipeline flush for FLUSH_CYCLES.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);

  logic [31:0]      status_f_s;
  logic [31:0]      cause_f_s;
  logic [31:0]      epc_f_s;
  logic             irq_s;
  logic             int_req_s;
  logic [31:0]      code_s;
  logic             accept_s;
  logic             take_int_s;
  logic [31:0]      target_pc_s;
  logic             unused_bits_s;
  state_e           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      new_pc_r;
  logic             int_pending_r;

  exception_ctrl_cp0_fwd u_cp0_fwd (
    .status   (bus.cp0_status_i),
    .cause    (bus.cp0_cause_i),
    .epc      (bus.cp0_epc_i),
    .wb_we    (bus.wb_cp0_we_i),
    .wb_waddr (bus.wb_cp0_waddr_i),
    .wb_data  (bus.wb_cp0_data_i),
    .status_f (status_f_s),
    .cause_f  (cause_f_s),
    .epc_f    (epc_f_s)
  );

  assign irq_s       = status_f_s[0] & ~status_f_s[1] & (|(cause_f_s[15:8] & status_f_s[15:8]));
  assign int_req_s   = int_pending_r | irq_s;
  assign code_s      = exc_code(int_req_s, bus.addr_err_i, bus.syscall_i, bus.inst_invalid_i,
                                bus.trap_i, bus.ovf_i, bus.eret_i);
  // Bubbles never take events, including interrupts
  assign accept_s    = ~rst & (state_r == ST_IDLE) & bus.valid_i & (code_s != EXC_NONE);
  assign take_int_s  = accept_s & (code_s == EXC_INT);
  assign target_pc_s = (code_s == EXC_ERET) ? epc_f_s : EXC_VECTOR;
  assign unused_bits_s = ^{status_f_s[31:16], status_f_s[7:2], cause_f_s[31:16], cause_f_s[7:0]};

  assign bus.cur_inst_addr_o = bus.inst_addr_i;
  assign bus.in_delay_slot_o = bus.in_delay_slot_i;
  assign bus.bad_addr_o      = bus.bad_addr_i;

  // Accept cycle is reported combinationally so cp0_reg captures it on this edge
  always_comb begin
    bus.excepttype_o = EXC_NONE;
    bus.flush_o      = 1'b0;
    bus.new_pc_o     = 32'h0000_0000;
    if (accept_s) begin
      bus.excepttype_o = code_s;
      bus.flush_o      = 1'b1;
      bus.new_pc_o     = target_pc_s;
    end else if (state_r == ST_FLUSH) begin
      bus.flush_o      = 1'b1;
      bus.new_pc_o     = new_pc_r;
    end else begin
      bus.flush_o      = 1'b0;
    end
  end

  // Flush sequencer and level-sensitive interrupt pending latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      new_pc_r      <= 32'h0000_0000;
      int_pending_r <= 1'b0;
    end else begin
      int_pending_r <= irq_s & ~take_int_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            new_pc_r <= target_pc_s;
            if (FLUSH_CYCLES > 1) begin
              state_r <= ST_FLUSH;
              cnt_r   <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          if (cnt_r <= CNT_W'(1)) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed plus randomized bench for exception_ctrl against a cycle-level
// behavioural model of the exception/flush rules.
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'h0000_0020;
  localparam int          FC  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exception_ctrl_if bus ();

  exception_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          m_left = 0;
  logic [31:0] m_pc   = 32'h0;
  logic        m_pend = 1'b0;
  // expectations for the current cycle
  logic [31:0] e_type, e_pc;
  logic        e_flush, e_irq, e_taken;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.valid_i = 1'b0;        bus.inst_addr_i = 32'h0;   bus.in_delay_slot_i = 1'b0;
    bus.bad_addr_i = 32'h0;    bus.addr_err_i = 1'b0;     bus.syscall_i = 1'b0;
    bus.inst_invalid_i = 1'b0; bus.trap_i = 1'b0;         bus.ovf_i = 1'b0;
    bus.eret_i = 1'b0;         bus.cp0_status_i = 32'h0;  bus.cp0_cause_i = 32'h0;
    bus.cp0_epc_i = 32'h0;     bus.wb_cp0_we_i = 1'b0;    bus.wb_cp0_waddr_i = 5'd0;
    bus.wb_cp0_data_i = 32'h0;
  endtask

  // Compute expected outputs for the current inputs, then compare
  task automatic settle();
    logic [31:0] st, ca, ep;
    logic        flags [7];
    logic [31:0] codes [7];
    st = bus.cp0_status_i;
    ca = bus.cp0_cause_i;
    ep = bus.cp0_epc_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd12) st = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd14) ep = bus.wb_cp0_data_i;
    if (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == 5'd13) begin
      ca[9:8]   = bus.wb_cp0_data_i[9:8];
      ca[23:22] = bus.wb_cp0_data_i[23:22];
    end
    e_irq   = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
    e_taken = 1'b0;
    e_type  = 32'h0;
    e_flush = 1'b0;
    e_pc    = 32'h0;
    flags[0] = m_pend || e_irq;  codes[0] = 32'h1;
    flags[1] = bus.addr_err_i;     codes[1] = 32'hf;
    flags[2] = bus.syscall_i;      codes[2] = 32'h8;
    flags[3] = bus.inst_invalid_i; codes[3] = 32'ha;
    flags[4] = bus.trap_i;         codes[4] = 32'hd;
    flags[5] = bus.ovf_i;          codes[5] = 32'hc;
    flags[6] = bus.eret_i;         codes[6] = 32'he;
    if (m_left > 0) begin
      e_flush = 1'b1;
      e_pc    = m_pc;
    end else if (bus.valid_i && !rst) begin
      for (int i = 0; i < 7; i++) begin
        if (flags[i] && !e_flush) begin
          e_type  = codes[i];
          e_flush = 1'b1;
          e_pc    = (i == 6) ? ep : VEC;
          e_taken = (i == 0);
        end
      end
    end
    #1;
    check32("excepttype", bus.excepttype_o, e_type);
    check32("flush", {31'h0, bus.flush_o}, {31'h0, e_flush});
    check32("new_pc", bus.new_pc_o, e_pc);
    check32("cur_inst_addr", bus.cur_inst_addr_o, bus.inst_addr_i);
    check32("in_delay_slot", {31'h0, bus.in_delay_slot_o}, {31'h0, bus.in_delay_slot_i});
    check32("bad_addr", bus.bad_addr_o, bus.bad_addr_i);
  endtask

  // Advance the model across the clock edge, return at the falling edge
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_pc   = 32'h0;
      m_pend = 1'b0;
    end else begin
      if (m_left > 0) begin
        m_left--;
      end else if (e_flush) begin
        m_pc   = e_pc;
        m_left = FC - 1;
      end
      m_pend = e_irq && !e_taken;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    settle(); tick();
    settle(); tick();
    rst = 1'b0;
    settle();
    check32("reset_flush", {31'h0, bus.flush_o}, 32'h0);
    check32("reset_new_pc", bus.new_pc_o, 32'h0);
    tick();

    // syscall: code 8, two flush cycles to the vector
    bus.valid_i = 1'b1; bus.syscall_i = 1'b1; bus.inst_addr_i = 32'h100;
    settle();
    check32("t1_type", bus.excepttype_o, 32'h8);
    check32("t1_pc", bus.new_pc_o, 32'h20);
    tick(); clear_inputs();
    settle();
    check32("t1_flush2", {31'h0, bus.flush_o}, 32'h1);
    check32("t1_type2", bus.excepttype_o, 32'h0);
    tick();
    settle();
    check32("t1_flush_end", {31'h0, bus.flush_o}, 32'h0);
    tick();

    // eret with EPC forwarded from WB
    bus.valid_i = 1'b1; bus.eret_i = 1'b1; bus.cp0_epc_i = 32'h40;
    bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd14; bus.wb_cp0_data_i = 32'h80;
    settle();
    check32("t2_type", bus.excepttype_o, 32'he);
    check32("t2_pc", bus.new_pc_o, 32'h80);
    tick(); clear_inputs(); settle(); tick();

    // interrupt held off by bubbles, taken on first valid slot
    bus.cp0_status_i = 32'h0000_0401; bus.cp0_cause_i = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      settle();
      check32("t3_bubble", {31'h0, bus.flush_o}, 32'h0);
      tick();
    end
    bus.valid_i = 1'b1;
    settle();
    check32("t3_type", bus.excepttype_o, 32'h1);
    check32("t3_pc", bus.new_pc_o, 32'h20);
    tick(); clear_inputs(); settle(); tick();

    // addr_err beats ovf
    bus.valid_i = 1'b1; bus.ovf_i = 1'b1; bus.addr_err_i = 1'b1; bus.bad_addr_i = 32'hdead_0000;
    settle();
    check32("t4_type", bus.excepttype_o, 32'hf);
    check32("t4_bad", bus.bad_addr_o, 32'hdead_0000);
    tick(); clear_inputs(); settle(); tick();

    // trap ignored in FLUSH, irq raised in FLUSH taken at next IDLE
    bus.valid_i = 1'b1; bus.syscall_i = 1'b1;
    settle(); tick();
    bus.syscall_i = 1'b0; bus.trap_i = 1'b1;
    bus.cp0_status_i = 32'h0000_0401; bus.cp0_cause_i = 32'h0000_0400;
    settle();
    check32("t5_ignored", bus.excepttype_o, 32'h0);
    tick();
    settle();
    check32("t5_int", bus.excepttype_o, 32'h1);
    tick(); clear_inputs(); settle(); tick();

    // eret loses to a pending interrupt
    bus.valid_i = 1'b1; bus.eret_i = 1'b1; bus.cp0_epc_i = 32'h500;
    bus.cp0_status_i = 32'h0000_0801; bus.cp0_cause_i = 32'h0000_0800;
    settle();
    check32("t7_int_over_eret", bus.excepttype_o, 32'h1);
    tick(); clear_inputs(); settle(); tick();

    // reset in the second flush cycle
    bus.valid_i = 1'b1; bus.inst_invalid_i = 1'b1;
    settle(); tick();
    clear_inputs(); rst = 1'b1;
    settle(); tick();
    rst = 1'b0;
    settle();
    check32("t6_flush", {31'h0, bus.flush_o}, 32'h0);
    check32("t6_pc", bus.new_pc_o, 32'h0);
    tick();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.valid_i         = ($urandom_range(3) != 0);
      bus.inst_addr_i     = $urandom;
      bus.in_delay_slot_i = 1'($urandom_range(1));
      bus.bad_addr_i      = $urandom;
      bus.addr_err_i      = ($urandom_range(9) == 0);
      bus.syscall_i       = ($urandom_range(9) == 0);
      bus.inst_invalid_i  = ($urandom_range(9) == 0);
      bus.trap_i          = ($urandom_range(9) == 0);
      bus.ovf_i           = ($urandom_range(9) == 0);
      bus.eret_i          = ($urandom_range(9) == 0);
      bus.cp0_status_i    = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      bus.cp0_cause_i     = ($urandom_range(3) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
      bus.cp0_epc_i       = $urandom;
      bus.wb_cp0_we_i     = ($urandom_range(3) == 0);
      bus.wb_cp0_waddr_i  = 5'(11 + $urandom_range(4));
      bus.wb_cp0_data_i   = $urandom;
      rst                 = ($urandom_range(49) == 0);
      settle();
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    settle(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
